// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC block-RAM arbiter: state encoding, owner codes
// and default geometry.
package fsmc_pkg;

   localparam int AW_DEF       = 8;
   localparam int DW_DEF       = 16;
   localparam int MAX_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } state_t;

   localparam logic OWN_HOST = 1'b0;
   localparam logic OWN_INT  = 1'b1;

endpackage

// File: rtl/fsmc_ram_arbiter.sv
// Serialises host and internal-engine accesses to the single-port block RAM behind
// the FSMC window; host has priority, the internal port is protected by a wait counter.
module fsmc_ram_arbiter
   import fsmc_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_ack,
   output logic [DW-1:0] h_rdata,

   input  logic          i_req,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,

   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,

   output logic          busy
);

   localparam int              WCW        = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0]  WAIT_LIMIT = WCW'(MAX_WAIT);

   state_t         r_state;
   logic           r_owner;
   logic           r_we;
   logic [WCW-1:0] r_wait_cnt;

   logic           w_wait_full;
   logic           w_grant_host;
   logic           w_grant_int;

   // Host wins any contest unless the internal port has already waited MAX_WAIT grants.
   always_comb begin
      w_wait_full  = (r_wait_cnt == WAIT_LIMIT);
      w_grant_host = h_req && !(i_req && w_wait_full);
      w_grant_int  = i_req && !w_grant_host;
   end

   // NOTE: every register here, outputs included, is updated with <= so all of them
   // see the same pre-edge values; the reset branch clears both rdata registers too.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_owner    <= OWN_HOST;
         r_we       <= 1'b0;
         r_wait_cnt <= '0;
         h_ack      <= 1'b0;
         h_rdata    <= '0;
         i_ack      <= 1'b0;
         i_rdata    <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!i_req) begin
                  r_wait_cnt <= '0;
               end
               if (w_grant_host) begin
                  r_owner   <= OWN_HOST;
                  r_we      <= h_we;
                  ram_en    <= 1'b1;
                  ram_we    <= h_we;
                  ram_addr  <= h_addr;
                  ram_wdata <= h_wdata;
                  busy      <= 1'b1;
                  r_state   <= ST_ISSUE;
                  if (i_req && !w_wait_full) begin
                     r_wait_cnt <= r_wait_cnt + WCW'(1);
                  end
               end else if (w_grant_int) begin
                  r_owner    <= OWN_INT;
                  r_we       <= i_we;
                  ram_en     <= 1'b1;
                  ram_we     <= i_we;
                  ram_addr   <= i_addr;
                  ram_wdata  <= i_wdata;
                  busy       <= 1'b1;
                  r_wait_cnt <= '0;
                  r_state    <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               ram_en    <= 1'b0;
               ram_we    <= 1'b0;
               ram_addr  <= '0;
               ram_wdata <= '0;
               r_state   <= ST_CAPTURE;
            end

            // RAM data is valid this cycle; writes leave the owner's rdata untouched.
            ST_CAPTURE: begin
               if (r_owner == OWN_HOST) begin
                  h_ack <= 1'b1;
                  if (!r_we) begin
                     h_rdata <= ram_rdata;
                  end
               end else begin
                  i_ack <= 1'b1;
                  if (!r_we) begin
                     i_rdata <= ram_rdata;
                  end
               end
               r_state <= ST_ACK;
            end

            ST_ACK: begin
               h_ack   <= 1'b0;
               i_ack   <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fsmc_ram_arbiter.md
# fsmc_ram_arbiter

Arbiter that shares the single-port synchronous block RAM behind the FSMC 0x0100 window between two requesters. The requesters are the FSMC host-side decoder (host port, `h_*`) and an internal engine (internal port, `i_*`). The block serialises accesses, gives the host fixed priority with a starvation guard for the internal port, and returns read data with a one-cycle acknowledge pulse.

## Interface
- `AW`, 8, RAM address width
- `DW`, 16, data width
- `MAX_WAIT`, 4, consecutive host grants allowed while the internal port waits (legal range ≥1)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `h_req`  in  1  host request; level, held until `h_ack`
- `h_we`  in  1  host write (1) / read (0)
- `h_addr`  in  AW  host address
- `h_wdata`  in  DW  host write data
- `h_ack`  out  1  host access complete, 1-cycle pulse
- `h_rdata`  out  DW  host read data, valid while `h_ack`=1, held afterwards
- `i_req`, `i_we`, `i_addr`, `i_wdata`, `i_ack`, `i_rdata`  same widths and semantics, internal port
- `ram_en`  out  1  RAM enable
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_rdata`  in  DW  RAM read data; 1-cycle latency after `ram_en`
- `busy`  out  1  arbiter not in IDLE

## Operation
- **FSM states:** IDLE → ISSUE → CAPTURE → ACK → IDLE. There are no other transitions; ISSUE, CAPTURE and ACK each last exactly one cycle.
- **IDLE, grant decision:**
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant host unless `wait_cnt == MAX_WAIT`, in which case grant internal.
  - The grant latches the owner plus the owner's we/addr/wdata into registers.
- **ISSUE:** `ram_en`=1, `ram_we`=latched we, address and data driven from the latched registers.
- **CAPTURE:** RAM outputs idle (`ram_en`=0). On a read, `ram_rdata` is registered into the owner's rdata register. On a write, the owner's rdata is left unchanged.
- **ACK:** the owner's ack = 1. The other port's ack stays 0.
- **Requester rule:** the requester must drop req in the cycle after ack. The arbiter ignores req in ISSUE, CAPTURE and ACK, so a req held through ACK re-arbitrates in IDLE as a new access.
- **`wait_cnt`:**
  - Increments, saturating at `MAX_WAIT`, on each host grant made while `i_req`=1.
  - Cleared on an internal grant, and in IDLE when `i_req`=0.
- **Fairness:** with `MAX_WAIT`=1 and both ports continuously requesting, grants strictly alternate.
- **Output ownership:** all outputs are registered. `ram_*` outputs are 0 outside ISSUE.
- **Reset, any state:** state=IDLE, `wait_cnt`=0, every output 0 (including both rdata registers and `busy`). An access in flight is aborted with no ack. A write already issued in ISSUE stands in the RAM.

## Timing
- **Host read, cycle by cycle:**
  - Cycle 0: IDLE samples `h_req`=1.
  - Cycle 1: ISSUE, `ram_en`=1.
  - Cycle 2: CAPTURE.
  - Cycle 3: `h_ack`=1 and `h_rdata` valid.
- **Latency:** req→ack is 3 cycles. Back-to-back throughput is one access per 4 cycles (IDLE included).
- **`busy`:** =1 in ISSUE, CAPTURE and ACK.
- **Starvation bound:** an internal request is served within `(MAX_WAIT+1)*4` cycles of assertion.
- **Simultaneous req rise:** the host wins when `wait_cnt < MAX_WAIT`.
- **Address width:** `AW` bits, no wrap logic. The address passes through unchanged.

## Structure
- **Shared package `fsmc_pkg`:**
  - State encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, ACK=2'd3.
  - Owner constants: OWN_HOST=1'b0, OWN_INT=1'b1.
  - Default `AW`/`DW`.
- **Hierarchy:** no sub-module. The grant logic is a few lines and stays inline with the FSM. The RAM itself sits outside this block.

## Test plan
- **Reset values:** hold `rst_n`=0 for 5 cycles → all outputs 0, `busy`=0. Release, no req → RAM outputs stay 0.
- **Host write/read:**
  - Host writes 0xA5A5 to addr 0x03 → `ram_we`=1 with `ram_addr`=0x03 in cycle 1, `h_ack` in cycle 3.
  - Host reads 0x03 → `h_rdata`=0xA5A5 with `h_ack` 3 cycles after req.
- **Simultaneous requests:** both ports write distinct values to 0x10/0x11 in the same cycle, `MAX_WAIT`=4 → host acked first, internal acked 4 cycles later. Read-back returns both values.
- **Starvation:**
  - `h_req` held continuously (re-asserted after each ack), `i_req` held, `MAX_WAIT`=4 → exactly 4 host grants, then 1 internal, repeating.
  - `MAX_WAIT`=1 → strict alternation.
- **Reset mid-operation:** assert `rst_n`=0 during CAPTURE of a host read → no `h_ack`, `h_rdata`=0. A subsequent read of the same address completes normally.
- **Read-data isolation:** internal read of 0x20 (preloaded 0x1234) while the host writes 0x21 → `i_rdata`=0x1234, `h_rdata` unchanged by the internal access.
